// File: rtl/tri_arb_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
package tri_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req scanning ptr, ptr+1, ... modulo N.
module rr_pick
  import tri_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            valid
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    // Scan from the farthest offset down so the closest requester to ptr is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (ID_W + 1)'(i);
      if (sum >= (ID_W + 1)'(N)) sum = sum - (ID_W + 1)'(N);
      idx = sum[ID_W-1:0];
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus with an all-off turnaround gap.
// Optional owner preemption after MAX_HOLD cycles is built when TRI_ARB_TIMEOUT_EN is defined.
module tri_bus_arbiter
  import tri_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int TURN_CYC = 1,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = id_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] owner,
  output logic            busy,
  output logic            turn
);

  localparam int TC_W = cnt_w(TURN_CYC);

  if (N < 2 || TURN_CYC < 1 || MAX_HOLD < 1) begin : g_bad_params
    $error("tri_bus_arbiter: illegal parameter values");
  end

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [TC_W-1:0] tc_q, tc_d;
  logic [N-1:0]    gnt_d;
  logic [ID_W-1:0] owner_d;
  logic            turn_d;
  logic            busy_d;
  logic            grant_new;
  logic            release_now;
  logic [ID_W-1:0] win_idx;
  logic            win_valid;

`ifdef TRI_ARB_TIMEOUT_EN
  localparam int HOLD_W = cnt_w(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win_idx),
    .valid  (win_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tc_d        = tc_q;
    gnt_d       = gnt;
    owner_d     = owner;
    turn_d      = turn;
    grant_new   = 1'b0;
    release_now = 1'b0;
`ifdef TRI_ARB_TIMEOUT_EN
    hold_d      = hold_q;
`endif

    case (state_q)
      IDLE: begin
        if (win_valid) grant_new = 1'b1;
      end

      GRANT: begin
        release_now = !req[owner];
`ifdef TRI_ARB_TIMEOUT_EN
        if (hold_q == HOLD_W'(MAX_HOLD) && |(req & ~gnt)) release_now = 1'b1;
`endif
        if (release_now) begin
          gnt_d   = '0;
          ptr_d   = (owner == ID_W'(N - 1)) ? '0 : owner + ID_W'(1);
          tc_d    = TC_W'(TURN_CYC);
          turn_d  = 1'b1;
          state_d = TURN;
        end
`ifdef TRI_ARB_TIMEOUT_EN
        else if (hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end

      TURN: begin
        // Requests are only looked at on the edge that closes the last turnaround cycle.
        if (tc_q == TC_W'(1)) begin
          turn_d = 1'b0;
          if (win_valid) grant_new = 1'b1;
          else           state_d   = IDLE;
        end else begin
          tc_d = tc_q - TC_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (grant_new) begin
      gnt_d          = '0;
      gnt_d[win_idx] = 1'b1;
      owner_d        = win_idx;
      state_d        = GRANT;
`ifdef TRI_ARB_TIMEOUT_EN
      hold_d         = HOLD_W'(1);
`endif
    end

    busy_d = |gnt_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tc_q    <= '0;
      gnt     <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      turn    <= 1'b0;
`ifdef TRI_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tc_q    <= tc_d;
      gnt     <= gnt_d;
      owner   <= owner_d;
      busy    <= busy_d;
      turn    <= turn_d;
`ifdef TRI_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter; reference model follows the arbitration rules with plain integers.
module tb_tri_bus_arbiter;

  localparam int N        = 4;
  localparam int TURN_CYC = 1;
  localparam int MAX_HOLD = 8;
  localparam int ID_W     = 2;
`ifdef TRI_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] owner;
  logic            busy;
  logic            turn;

  int checks = 0;
  int errors = 0;

  // Reference model state: current owner (-1 = none), remaining gap cycles, priority start, last owner, hold length.
  int m_own;
  int m_gap;
  int m_ptr;
  int m_last;
  int m_hold;

  tri_bus_arbiter #(.N(N), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .turn  (turn)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_own  = -1;
    m_gap  = 0;
    m_ptr  = 0;
    m_last = 0;
    m_hold = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    if (m_own >= 0) begin
      others = r & ~(N'(1) << m_own);
      if (((r >> m_own) & N'(1)) == '0 || (TO && m_hold >= MAX_HOLD && others != '0)) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
        m_gap = TURN_CYC;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
      return;
    end
    if (m_gap > 0) begin
      m_gap--;
      if (m_gap > 0) return;
    end
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (((r >> k) & N'(1)) != '0) begin
        m_own  = k;
        m_last = k;
        m_hold = 1;
        return;
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    return (m_own >= 0) ? (N'(1) << m_own) : '0;
  endfunction

  // Drive req, let one active edge pass, advance the model, then settle 1 time unit past the edge.
  task automatic tick(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || turn !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: gnt=%b busy=%b turn=%b owner=%0d required gnt=0000 busy=0 turn=0 owner=0", gnt, busy, turn, owner);
    end
    #2 rst_n = 1'b1;
    tick(4'b1111);
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1 || turn !== 1'b0) begin
      errors++;
      $display("FAIL first_grant: gnt=%b owner=%0d busy=%b turn=%b required gnt=0001 owner=0 busy=1 turn=0", gnt, owner, busy, turn);
    end
  endtask

  task automatic test_handoff();
    tick(4'b0101);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL handoff_hold: gnt=%b required 0001", gnt);
    end
    tick(4'b0100);
    checks++;
    if (gnt !== 4'b0000 || turn !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handoff_turn: gnt=%b turn=%b busy=%b required gnt=0000 turn=1 busy=0", gnt, turn, busy);
    end
    tick(4'b0100);
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2 || turn !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL handoff_grant: gnt=%b owner=%0d turn=%b busy=%b required gnt=0100 owner=2 turn=0 busy=1", gnt, owner, turn, busy);
    end
  endtask

  task automatic test_wrap();
    tick(4'b0001);
    checks++;
    if (gnt !== 4'b0000 || turn !== 1'b1) begin
      errors++;
      $display("FAIL wrap_turn: gnt=%b turn=%b required gnt=0000 turn=1", gnt, turn);
    end
    tick(4'b0101);
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL wrap_grant: gnt=%b owner=%0d required gnt=0001 owner=0", gnt, owner);
    end
    tick(4'b0000);
    tick(4'b0000);
    checks++;
    if (gnt !== 4'b0000 || turn !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle: gnt=%b turn=%b busy=%b required all zero", gnt, turn, busy);
    end
  endtask

  task automatic test_single_toggle();
    logic [N-1:0] prev;
    int grants;
    prev   = gnt;
    grants = 0;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 4; c++) begin
        tick((c < 3) ? 4'b0010 : 4'b0000);
        checks++;
        if (gnt !== exp_gnt() || turn !== (m_own < 0 && m_gap > 0)) begin
          errors++;
          $display("FAIL toggle_model p=%0d c=%0d: gnt=%b turn=%b required gnt=%b turn=%b", p, c, gnt, turn, exp_gnt(), (m_own < 0 && m_gap > 0));
        end
        checks++;
        if ($countones(gnt) > 1 || (gnt !== 4'b0000 && prev !== 4'b0000 && gnt !== prev)) begin
          errors++;
          $display("FAIL toggle_gap p=%0d c=%0d: gnt=%b after %b required one-hot with an off cycle between grants", p, c, gnt, prev);
        end
        if (gnt !== 4'b0000 && prev === 4'b0000) grants++;
        prev = gnt;
      end
    end
    checks++;
    if (grants != 6) begin
      errors++;
      $display("FAIL toggle_grant_count: got %0d grants required 6", grants);
    end
  endtask

  task automatic test_async_reset();
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0100);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL areset_setup: gnt=%b required 0100", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || turn !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL areset_immediate: gnt=%b busy=%b turn=%b owner=%0d required all zero", gnt, busy, turn, owner);
    end
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(4'b0100);
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_regrant: gnt=%b owner=%0d busy=%b required gnt=0100 owner=2 busy=1", gnt, owner, busy);
    end
  endtask

  task automatic test_hold();
    logic [N-1:0] prev;
    int run;
    int releases;
    tick(4'b0000);
    tick(4'b0000);
    prev     = gnt;
    run      = 0;
    releases = 0;
    for (int c = 0; c < 40; c++) begin
      tick(4'b0011);
      checks++;
      if (gnt !== exp_gnt()) begin
        errors++;
        $display("FAIL hold_model c=%0d: gnt=%b required %b", c, gnt, exp_gnt());
      end
      if (gnt !== 4'b0000 && gnt === prev) run++;
      else if (gnt !== 4'b0000) run = 1;
      else if (prev !== 4'b0000) begin
        releases++;
`ifdef TRI_ARB_TIMEOUT_EN
        checks++;
        if (run != MAX_HOLD) begin
          errors++;
          $display("FAIL hold_run_length c=%0d: held %0d cycles required %0d", c, run, MAX_HOLD);
        end
`endif
      end
      prev = gnt;
    end
`ifdef TRI_ARB_TIMEOUT_EN
    checks++;
    if (releases < 3) begin
      errors++;
      $display("FAIL hold_preempt_count: %0d preemptions required at least 3", releases);
    end
`else
    checks++;
    if (releases != 0 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL hold_no_timeout: %0d releases gnt=%b required 0 releases gnt=0001", releases, gnt);
    end
`endif
    tick(4'b0000);
    tick(4'b0000);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    r = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      tick(r);
      checks++;
      if (gnt !== exp_gnt() || busy !== (m_own >= 0) || turn !== (m_own < 0 && m_gap > 0)) begin
        errors++;
        $display("FAIL random_outputs c=%0d req=%b: gnt=%b busy=%b turn=%b required gnt=%b busy=%b turn=%b",
                 c, r, gnt, busy, turn, exp_gnt(), (m_own >= 0), (m_own < 0 && m_gap > 0));
      end
      if (busy === 1'b1) begin
        checks++;
        if (owner !== ID_W'(m_last)) begin
          errors++;
          $display("FAIL random_owner c=%0d: owner=%0d required %0d", c, owner, m_last);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_handoff();
    test_wrap();
    test_single_toggle();
    test_async_reset();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
